serial_mag_comp: RTL
====================

# serial_mag_comp

Bit-serial WIDTH-bit magnitude comparator built around the 1-bit `meg_comp` cell, instantiated once internally. It is the word-level stage directly downstream of that cell. Two operands are latched on a start request, then walked MSB-first one bit pair per clock through the 1-bit comparator. The block stops at the first differing bit and reports greater/less/equal with a one-cycle done pulse. It trades latency for area wherever a full parallel comparator is not justified.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A, sampled on the edge that accepts start.
- b  input  WIDTH  operand B, sampled on the edge that accepts start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- greater  output  1  registered result, a > b.
- less  output  1  registered result, a < b.
- equal  output  1  registered result, a == b.

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- **IDLE:** on a rising edge with start=1:
  - load sh_a←a and sh_b←b;
  - set bit counter cnt←WIDTH-1;
  - go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** each cycle feed sh_a[WIDTH-1] and sh_b[WIDTH-1] into the `meg_comp` instance.
  - Cell greater=1: register greater=1, less=0, equal=0; go to DONE.
  - Cell less=1: register less=1, greater=0, equal=0; go to DONE.
  - Cell equal=1 and cnt==0: register equal=1, greater=0, less=0; go to DONE.
  - Cell equal=1 and cnt>0: shift sh_a and sh_b left by 1, decrement cnt, stay in SHIFT.
- **DONE:** done=1 for this single cycle, then unconditionally return to IDLE. start is ignored in DONE.
- Result registers are written only on the edge entering DONE. They hold their value until the next such edge; accepting a new start does not clear them.
- After the first completion, exactly one of greater/less/equal is high.
- a and b are don't-care except on the accepting edge. Changes while busy=1 have no effect.
- start during SHIFT or DONE is ignored and not queued. A start still high in the following IDLE cycle is accepted then.
- cnt is $clog2(WIDTH) bits wide and never wraps. The cnt==0 check is made before any decrement.

## Timing
- Reset (asynchronous, immediate, including mid-SHIFT):
  - state=IDLE;
  - busy=0, done=0, greater=0, less=0, equal=0;
  - shift registers and cnt cleared;
  - any in-flight comparison is discarded with no done pulse.
- Let E0 be the edge that accepts start, and p the index of the most significant differing bit.
  - Unequal operands: SHIFT lasts WIDTH-p cycles. done and the result are high in the cycle after edge E0+(WIDTH-p).
  - Equal operands: SHIFT lasts WIDTH cycles. done and equal are high in the cycle after edge E0+WIDTH.
- busy rises in the cycle after E0 and stays high through the DONE cycle: (WIDTH-p)+1 cycles, or WIDTH+1 when the operands are equal.
- Minimum start-to-start spacing is SHIFT length + 2 cycles. A new start can be accepted on the edge that leaves DONE→IDLE plus one.
- The result outputs rise on the same edge as done.

## Test plan
- **Reset behaviour (WIDTH=8):**
  - Stimulus: assert rst at time 0, then release it and start a=0x55, b=0x55; pulse rst two cycles into SHIFT.
  - Required response: busy, done, greater, less and equal all go 0 immediately (not at a clock edge); no done pulse follows; the next start compares normally.
- **MSB decides (WIDTH=8):**
  - Stimulus: a=0x80, b=0x7F.
  - Required response: greater=1 and done=1 in the cycle after E0+1; busy high for exactly 2 cycles.
- **LSB decides (WIDTH=8):**
  - Stimulus: a=0x12, b=0x13.
  - Required response: less=1 and done after E0+8; busy high for 9 cycles; greater=0, equal=0.
- **Equal operands (WIDTH=8):**
  - Stimulus: a=b=0x3C.
  - Required response: equal=1 and done after E0+8.
  - Follow-up: start a=0xFF, b=0x00. The held equal=1 stays until the edge E0'+1, when it switches to greater=1.
- **Ignored inputs (WIDTH=8):**
  - Stimulus: hold start=1 continuously; flip a and b every cycle while busy.
  - Required response: each result matches the operands sampled at its accepting edge; done pulses are spaced SHIFT length + 2 cycles apart; done is never high for 2 consecutive cycles.
- **Minimum width and cnt boundary (WIDTH=2):**
  - Stimulus: a=2'b01, b=2'b01, then a=2'b01, b=2'b00.
  - Required response: equal after E0+2, then greater after E0+2. Checks that cnt does not underflow at the cnt==0 boundary.

Source files
------------

// File: rtl/serial_mag_comp_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The master side issues start with operands; the slave side reports status and result.
interface serial_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             less;
    logic             equal;

    modport master (
        output start, a, b,
        input  busy, done, greater, less, equal
    );

    modport slave (
        input  start, a, b,
        output busy, done, greater, less, equal
    );
endinterface

// File: rtl/serial_mag_comp.sv
// Bit-serial WIDTH-bit magnitude comparator: walks the operands MSB-first through a
// 1-bit compare cell and stops at the first differing bit.

module meg_comp (
    input  logic a,
    input  logic b,
    output logic greater,
    output logic less,
    output logic equal
);
    assign greater = a & ~b;
    assign less    = ~a & b;
    assign equal   = ~(a ^ b);
endmodule

module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_mag_comp_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             cell_gt;
    logic             cell_lt;
    logic             cell_eq;
    logic             res_gt;
    logic             res_lt;
    logic             res_eq;
    logic             decided;

    meg_comp u_cell (
        .a       (sh_a[WIDTH-1]),
        .b       (sh_b[WIDTH-1]),
        .greater (cell_gt),
        .less    (cell_lt),
        .equal   (cell_eq)
    );

    // The walk ends on a differing bit, or on a matching LSB (cnt tested before any decrement).
    assign decided = cell_gt | cell_lt | (cell_eq && cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (decided)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            res_gt <= 1'b0;
            res_lt <= 1'b0;
            res_eq <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sh_a <= bus.a;
                        sh_b <= bus.b;
                        cnt  <= CW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    if (decided) begin
                        // Cell outputs are one-hot, so they load the result directly.
                        res_gt <= cell_gt;
                        res_lt <= cell_lt;
                        res_eq <= cell_eq;
                    end else begin
                        sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                        sh_b <= {sh_b[WIDTH-2:0], 1'b0};
                        cnt  <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.greater = res_gt;
    assign bus.less    = res_lt;
    assign bus.equal   = res_eq;
endmodule
